fp_add_result_buffer: RTL and testbench
=======================================

# fp_add_result_buffer

Registered result buffer that sits directly downstream of the combinational `fp_adder`. It captures `fp_result`, `overflow` and `underflow` together with a destination tag under a valid/ready handshake. It holds results in a small FIFO until writeback accepts them. It also accumulates sticky IEEE exception flags (NV/OF/UF) for the FPU status register.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `TAG_W`, default 5: destination tag width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: adder output valid this cycle.
- `in_ready` output 1: buffer can accept; equals `!full`.
- `in_result` input 32: `fp_result` from adder.
- `in_overflow` input 1: adder `overflow`.
- `in_underflow` input 1: adder `underflow`.
- `in_tag` input TAG_W: destination tag travelling with the operation.
- `out_valid` output 1: head entry valid; equals `!empty`.
- `out_ready` input 1: writeback accepts head.
- `out_result` output 32: head result.
- `out_tag` output TAG_W: head tag.
- `out_flags` output 3: head flags {NV, OF, UF}.
- `fflags` output 3: sticky {NV, OF, UF}.
- `fflags_clr` input 1: clear sticky flags.
- `count` output $clog2(DEPTH)+1: occupied entries.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- On push, entry {in_result, in_tag, nv, in_overflow, in_underflow} is written at the write pointer.
- nv = (in_result[30:23] == 8'hFF) && (in_result[22:0] != 0).
- Storage and pointers are registered. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `full`, `empty`, `in_ready` and `out_valid` derive from registered `count` only. They never depend combinationally on `in_valid`/`out_ready`, so there are no comb paths through the block.
- Outputs `out_result`/`out_tag`/`out_flags` present the entry at the read pointer. Their value is don't-care when `empty`, but it must be stable while `out_valid && !out_ready`.
- Sticky flags: fflags_next = (fflags_clr ? 3'b000 : fflags) | (push ? {nv, in_overflow, in_underflow} : 3'b000).
  - Flags from a push in the same cycle as a clear survive.
  - Flags accumulate at acceptance, not at pop.
- When full, `in_ready`=0 and a pop in that cycle does not enable a push in the same cycle. The upstream source holds the operation, since the adder is combinational and its inputs must stay stable.
- Pop with `empty` is impossible (`out_valid`=0). Push with `full` is impossible (`in_ready`=0).
- Asynchronous reset (rst_n low):
  - Pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `in_ready` = 1, `out_valid` = 0, `fflags` = 0.
  - Storage contents are not reset.
  - A reset mid-operation discards all stored entries and sticky flags immediately, without waiting for a clock edge.

## Timing
- Latency: an entry pushed at edge N is visible with `out_valid`=1 after edge N. There is no same-cycle bypass.
- Throughput is one push and one pop per cycle when 0 < count < DEPTH.
- From full, a pop at edge N gives `in_ready`=1 after edge N.
- `fflags` updates at the edge of the push/clear; it is visible the following cycle.
- Exiting reset: the first push is accepted at the first rising edge with rst_n high.

## Test plan
- Reset, then push 32'h3F800000 tag 3 with out_ready=0 → next cycle out_valid=1, out_result=32'h3F800000, out_tag=3, out_flags=0, count=1, fflags=0.
- Push DEPTH=4 entries (tags 0..3) with out_ready=0 → full=1, in_ready=0. A 5th in_valid is not accepted. Then pop all four with out_ready=1 → tags exit 0,1,2,3 in order, followed by empty=1.
- Keep count=2 and hold in_valid=out_ready=1 for 10 cycles with incrementing tags → count stays 2, ordering preserved, pointers wrap past DEPTH without loss.
- Push 32'h7F800000 with in_overflow=1, then 32'h7FC00000 → fflags=3'b010 then 3'b110. Head out_flags for these entries are 010 and 100.
- Set fflags=3'b110, then assert fflags_clr in the same cycle as a push with in_underflow=1 → fflags=3'b001.
- With 3 entries stored and fflags=3'b111, drop rst_n between edges → count=0, empty=1, in_ready=1, out_valid=0, fflags=0 immediately. After release, a new push returns its own tag first.

Source files
------------

// File: rtl/fp_add_result_buffer.sv
// Result FIFO behind the combinational fp_adder.
// Holds {result, tag, flags} until writeback and keeps sticky NV/OF/UF.
module fp_add_result_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [2:0]               out_flags,
  output logic [2:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           push;
  logic           pop;
  logic           nv;
  logic [2:0]     in_flags;
  entry_t         head;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign nv       = (in_result[30:23] == 8'hFF) && (in_result[22:0] != '0);
  assign in_flags = {nv, in_overflow, in_underflow};

  assign head       = mem[rptr];
  assign out_result = head.result;
  assign out_tag    = head.tag;
  assign out_flags  = head.flags;

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{result: in_result, tag: in_tag, flags: in_flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

  // A clear never wipes flags arriving with the same push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= 3'b000;
    end else begin
      fflags <= (fflags_clr ? 3'b000 : fflags)
              | (push ? in_flags : 3'b000);
    end
  end

endmodule

// File: tb/tb_fp_add_result_buffer.sv
// Directed bench for fp_add_result_buffer.
// Queue-based reference model checked every cycle plus literal pins.
module tb_fp_add_result_buffer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_overflow;
  logic             in_underflow;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;
  logic [2:0]       fflags;
  logic             fflags_clr;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  fp_add_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow),
    .in_underflow(in_underflow), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_flags(out_flags), .fflags(fflags),
    .fflags_clr(fflags_clr), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entry = {result, tag, flags}
  logic [39:0] m_q[$];
  logic [2:0]  m_ff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ff = 3'b000;
    end else begin
      logic       acc;
      logic       take;
      logic       nvb;
      logic [2:0] fl;
      acc  = in_valid && (m_q.size() < DEPTH);
      take = out_ready && (m_q.size() > 0);
      nvb  = (in_result[30:23] == 8'hFF) && (in_result[22:0] != 0);
      fl   = {nvb, in_overflow, in_underflow};
      if (fflags_clr) m_ff = 3'b000;
      if (acc) m_ff = m_ff | fl;
      if (take) void'(m_q.pop_front());
      if (acc) m_q.push_back({in_result, in_tag, fl});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("count", 40'(count), 40'(m_q.size()));
      chk("empty", 40'(empty), 40'(m_q.size() == 0));
      chk("full", 40'(full), 40'(m_q.size() == DEPTH));
      chk("in_ready", 40'(in_ready), 40'(m_q.size() != DEPTH));
      chk("out_valid", 40'(out_valid), 40'(m_q.size() != 0));
      chk("fflags", 40'(fflags), 40'(m_ff));
      if (m_q.size() > 0)
        chk("head", {out_result, out_tag, out_flags}, m_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic ov, input logic uf,
                       input logic [TAG_W-1:0] t);
    in_valid     = v;
    in_result    = r;
    in_overflow  = ov;
    in_underflow = uf;
    in_tag       = t;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    fflags_clr = 1'b0;
    drive(0, 32'h0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_empty", 40'(empty), 40'd1);
    chk("rst_in_ready", 40'(in_ready), 40'd1);
    chk("rst_fflags", 40'(fflags), 40'd0);

    // single push
    drive(1, 32'h3F800000, 0, 0, 5'd3);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    chk("t1_out_valid", 40'(out_valid), 40'd1);
    chk("t1_result", 40'(out_result), 40'h3F800000);
    chk("t1_tag", 40'(out_tag), 40'd3);
    chk("t1_flags", 40'(out_flags), 40'd0);
    chk("t1_count", 40'(count), 40'd1);
    chk("t1_fflags", 40'(fflags), 40'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // fill to full, reject a fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40000000 + i, 0, 0, TAG_W'(i));
      tick();
    end
    chk("t2_full", 40'(full), 40'd1);
    chk("t2_in_ready", 40'(in_ready), 40'd0);
    drive(1, 32'h40400000, 0, 0, 5'd9);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    chk("t2_count", 40'(count), 40'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 40'(out_tag), 40'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("t2_empty", 40'(empty), 40'd1);

    // steady state with count=2, pointers wrapping
    drive(1, 32'h41000000, 0, 0, 5'd10);
    tick();
    drive(1, 32'h41100000, 0, 0, 5'd11);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h41200000 + k, 0, 0, TAG_W'(12 + k));
      chk("t3_tag", 40'(out_tag), 40'(10 + k));
      chk("t3_count", 40'(count), 40'd2);
      tick();
    end
    drive(0, 32'h0, 0, 0, 0);
    chk("t3_tail0", 40'(out_tag), 40'd20);
    tick();
    chk("t3_tail1", 40'(out_tag), 40'd21);
    tick();
    out_ready = 1'b0;
    chk("t3_empty", 40'(empty), 40'd1);

    // sticky flags and per-entry flags
    drive(1, 32'h7F800000, 1, 0, 5'd1);
    tick();
    chk("t4_ff_of", 40'(fflags), 40'b010);
    chk("t4_head_of", 40'(out_flags), 40'b010);
    drive(1, 32'h7FC00000, 0, 0, 5'd2);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    chk("t4_ff_nv", 40'(fflags), 40'b110);
    out_ready = 1'b1;
    tick();
    chk("t4_head_nv", 40'(out_flags), 40'b100);
    tick();
    out_ready = 1'b0;

    // clear concurrent with a flagged push
    fflags_clr = 1'b1;
    drive(1, 32'h3F800000, 0, 1, 5'd4);
    tick();
    fflags_clr = 1'b0;
    drive(0, 32'h0, 0, 0, 0);
    chk("t5_clr", 40'(fflags), 40'b001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // asynchronous reset mid-operation
    drive(1, 32'h7FC00000, 1, 1, 5'd5);
    tick();
    drive(1, 32'h3F800000, 0, 0, 5'd6);
    tick();
    tick();
    drive(0, 32'h0, 0, 0, 0);
    chk("t6_count3", 40'(count), 40'd3);
    chk("t6_ff111", 40'(fflags), 40'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 40'(count), 40'd0);
    chk("t6_rst_empty", 40'(empty), 40'd1);
    chk("t6_rst_in_ready", 40'(in_ready), 40'd1);
    chk("t6_rst_out_valid", 40'(out_valid), 40'd0);
    chk("t6_rst_fflags", 40'(fflags), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h3F000000, 0, 0, 5'd7);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    chk("t6_new_tag", 40'(out_tag), 40'd7);
    chk("t6_new_count", 40'(count), 40'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
